// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - owner tags and slot phases shared by the SDRAM slot arbiter
package mem_arb_pkg;

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_VID1,
    OWN_VID2,
    OWN_CPU,
    OWN_MISC
  } owner_t;

  localparam logic [3:0] PH_VID1   = 4'd0;
  localparam logic [3:0] PH_VID2   = 4'd4;
  localparam logic [3:0] PH_CPU    = 4'd8;
  localparam logic [3:0] PH_SHARED = 4'd12;

endpackage

// File: rtl/mem_wbuf.sv
// rtl/mem_wbuf.sv - one-entry download write buffer with sticky overflow flag
module mem_wbuf #(
  parameter int AW = 25
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    din_i,
  input  logic          issue_i,
  output logic          busy_o,
  output logic          ovf_o,
  output logic [AW-1:0] addr_o,
  output logic [7:0]    din_o
);

  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic          load;

  // A strobe may refill the entry in the very cycle it is handed to the arbiter.
  always_comb begin
    load   = wr_i && (!full_q || issue_i);
    full_d = full_q;
    ovf_d  = ovf_q;
    addr_d = addr_q;
    din_d  = din_q;
    if (issue_i) full_d = 1'b0;
    if (load) begin
      full_d = 1'b1;
      addr_d = addr_i;
      din_d  = din_i;
    end else if (wr_i) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      full_q <= full_d;
      ovf_q  <= ovf_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  assign busy_o = full_q;
  assign ovf_o  = ovf_q;
  assign addr_o = addr_q;
  assign din_o  = din_q;

endmodule

// File: rtl/mem_slot_arbiter.sv
// rtl/mem_slot_arbiter.sv - 16-phase slot wheel sharing the SDRAM port among video, Z80 and download
module mem_slot_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 25,
  parameter int LAT = 3
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [18:0]   vid_addr1,
  input  logic [18:0]   vid_addr2,
  output logic [15:0]   vid_data1,
  output logic [15:0]   vid_data2,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  input  logic          misc_wr,
  input  logic [AW-1:0] misc_addr,
  input  logic [7:0]    misc_din,
  output logic          misc_busy,
  output logic          misc_ovf,
  output logic          cmd_start,
  output logic          cmd_we,
  output logic          cmd_wide,
  output logic [AW-1:0] cmd_addr,
  output logic [7:0]    cmd_din,
  input  logic          rsp_valid,
  input  logic [15:0]   rsp_data
);

  localparam int PAD = AW - 20;

  logic [3:0]    phase_q, phase_d;
  owner_t        own_q, own_d;
  owner_t        tag_q [LAT];
  owner_t        tail;
  logic          start_q, start_d, we_q, we_d, wide_q, wide_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic          cpu_busy_q, cpu_busy_d, cpu_sel_q, cpu_sel_d, cpu_wr_q, cpu_wr_d;
  logic [15:0]   vid1_q, vid1_d, vid2_q, vid2_d;
  logic [7:0]    dout_q, dout_d;
  logic          ack_q, ack_d;
  logic          wb_full, wb_issue;
  logic [AW-1:0] wb_addr;
  logic [7:0]    wb_din;

  mem_wbuf #(.AW(AW)) u_wbuf (
    .clk_sys (clk_sys),
    .reset   (reset),
    .wr_i    (misc_wr),
    .addr_i  (misc_addr),
    .din_i   (misc_din),
    .issue_i (wb_issue),
    .busy_o  (wb_full),
    .ovf_o   (misc_ovf),
    .addr_o  (wb_addr),
    .din_o   (wb_din)
  );

  assign tail     = tag_q[LAT-1];
  assign wb_issue = (own_d == OWN_MISC);

  always_comb begin
    phase_d    = phase_q + 4'd1;
    own_d      = OWN_NONE;
    we_d       = we_q;
    wide_d     = wide_q;
    addr_d     = addr_q;
    din_d      = din_q;
    cpu_busy_d = cpu_busy_q;
    cpu_sel_d  = cpu_sel_q;
    cpu_wr_d   = cpu_wr_q;
    vid1_d     = vid1_q;
    vid2_d     = vid2_q;
    dout_d     = dout_q;
    ack_d      = 1'b0;

    case (phase_q)
      PH_VID1:   own_d = OWN_VID1;
      PH_VID2:   own_d = OWN_VID2;
      PH_CPU:    if (cpu_req && !cpu_busy_q) own_d = OWN_CPU;
      PH_SHARED: begin
        if (wb_full)                       own_d = OWN_MISC;
        else if (cpu_req && !cpu_busy_q)   own_d = OWN_CPU;
      end
      default:   own_d = OWN_NONE;
    endcase

    // Route the response that belongs to the command at the tag pipeline tail.
    case (tail)
      OWN_VID1: if (rsp_valid) vid1_d = rsp_data;
      OWN_VID2: if (rsp_valid) vid2_d = rsp_data;
      OWN_CPU: begin
        ack_d      = 1'b1;
        cpu_busy_d = 1'b0;
        if (rsp_valid && !cpu_wr_q) dout_d = cpu_sel_q ? rsp_data[15:8] : rsp_data[7:0];
      end
      default: ;
    endcase

    case (own_d)
      OWN_VID1: begin
        we_d = 1'b0; wide_d = 1'b1; din_d = 8'h00;
        addr_d = {{PAD{1'b0}}, vid_addr1, 1'b0};
      end
      OWN_VID2: begin
        we_d = 1'b0; wide_d = 1'b1; din_d = 8'h00;
        addr_d = {{PAD{1'b0}}, vid_addr2, 1'b0};
      end
      OWN_CPU: begin
        we_d = cpu_we; wide_d = 1'b0; addr_d = cpu_addr; din_d = cpu_din;
        cpu_busy_d = 1'b1; cpu_sel_d = cpu_addr[0]; cpu_wr_d = cpu_we;
      end
      OWN_MISC: begin
        we_d = 1'b1; wide_d = 1'b0; addr_d = wb_addr; din_d = wb_din;
      end
      default: ;
    endcase
    start_d = (own_d != OWN_NONE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      phase_q    <= PH_VID1;
      own_q      <= OWN_NONE;
      for (int i = 0; i < LAT; i++) tag_q[i] <= OWN_NONE;
      start_q    <= 1'b0;
      we_q       <= 1'b0;
      wide_q     <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      cpu_busy_q <= 1'b0;
      cpu_sel_q  <= 1'b0;
      cpu_wr_q   <= 1'b0;
      vid1_q     <= 16'h0000;
      vid2_q     <= 16'h0000;
      dout_q     <= 8'hFF;
      ack_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      own_q      <= own_d;
      tag_q[0]   <= own_q;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      start_q    <= start_d;
      we_q       <= we_d;
      wide_q     <= wide_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      cpu_busy_q <= cpu_busy_d;
      cpu_sel_q  <= cpu_sel_d;
      cpu_wr_q   <= cpu_wr_d;
      vid1_q     <= vid1_d;
      vid2_q     <= vid2_d;
      dout_q     <= dout_d;
      ack_q      <= ack_d;
    end
  end

  assign cmd_start = start_q;
  assign cmd_we    = we_q;
  assign cmd_wide  = wide_q;
  assign cmd_addr  = addr_q;
  assign cmd_din   = din_q;
  assign vid_data1 = vid1_q;
  assign vid_data2 = vid2_q;
  assign cpu_dout  = dout_q;
  assign cpu_ack   = ack_q;
  assign misc_busy = wb_full;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// tb/tb_mem_slot_arbiter.sv - directed bench for mem_slot_arbiter with a fixed-latency SDRAM model
module tb_mem_slot_arbiter;

  localparam int AW  = 25;
  localparam int LAT = 3;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [18:0]   vid_addr1, vid_addr2;
  logic [15:0]   vid_data1, vid_data2;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din, cpu_dout;
  logic          cpu_ack;
  logic          misc_wr;
  logic [AW-1:0] misc_addr;
  logic [7:0]    misc_din;
  logic          misc_busy, misc_ovf;
  logic          cmd_start, cmd_we, cmd_wide;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_din;
  logic          rsp_valid;
  logic [15:0]   rsp_data;

  int vectors = 0;
  int errs    = 0;
  int lab     = 0;
  int ph      = 0;

  always #5 clk_sys = ~clk_sys;

  mem_slot_arbiter #(.AW(AW), .LAT(LAT)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .vid_addr1 (vid_addr1),
    .vid_addr2 (vid_addr2),
    .vid_data1 (vid_data1),
    .vid_data2 (vid_data2),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_ack   (cpu_ack),
    .misc_wr   (misc_wr),
    .misc_addr (misc_addr),
    .misc_din  (misc_din),
    .misc_busy (misc_busy),
    .misc_ovf  (misc_ovf),
    .cmd_start (cmd_start),
    .cmd_we    (cmd_we),
    .cmd_wide  (cmd_wide),
    .cmd_addr  (cmd_addr),
    .cmd_din   (cmd_din),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  // SDRAM model: reads answer with the low 16 address bits exactly LAT cycles after cmd_start.
  logic [LAT-1:0] vpipe = '0;
  logic [15:0]    dpipe [LAT];
  always @(posedge clk_sys) begin
    vpipe    <= {vpipe[LAT-2:0], cmd_start && !cmd_we};
    dpipe[0] <= cmd_addr[15:0];
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign rsp_valid = vpipe[LAT-1];
  assign rsp_data  = dpipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s at phase %0d: observed=%0h expected=%0h", tag, ph, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    lab++;
    ph = lab % 16;
  endtask

  task automatic wait_ph(input int p);
    tick();
    while (ph != p) tick();
  endtask

  initial begin
    reset = 1'b1;
    vid_addr1 = 19'h41234; vid_addr2 = 19'h00ABC;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'h00;
    misc_wr = 1'b0; misc_addr = '0; misc_din = 8'h00;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("rst_cmd_start", cmd_start, 0);
    chk("rst_cmd_we", cmd_we, 0);
    chk("rst_cmd_wide", cmd_wide, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_din", cmd_din, 0);
    chk("rst_vid1", vid_data1, 0);
    chk("rst_vid2", vid_data2, 0);
    chk("rst_cpu_dout", cpu_dout, 8'hFF);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_misc_busy", misc_busy, 0);
    chk("rst_misc_ovf", misc_ovf, 0);

    // Two idle wheels: only the video slots issue.
    reset = 1'b0;
    lab = -1;
    for (int n = 0; n < 32; n++) begin
      tick();
      chk("idle_start", cmd_start, (ph == 0 || ph == 4) ? 1 : 0);
      if (ph == 0) begin
        chk("vid1_wide", cmd_wide, 1);
        chk("vid1_addr", cmd_addr, 32'h0082468);
      end
      if (ph == 4) chk("vid2_addr", cmd_addr, 32'h0001578);
      if (lab == 3) chk("vid1_early", vid_data1, 0);
      if (lab >= 4) chk("vid1_data", vid_data1, 16'h2468);
      if (lab >= 8) chk("vid2_data", vid_data2, 16'h1578);
    end

    // CPU read raised at phase 9 goes out in the shared slot.
    wait_ph(9);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0012345;
    tick();
    chk("rd_no_early", cmd_start, 0);
    tick(); tick();
    chk("rd_start", cmd_start, 1);
    chk("rd_we", cmd_we, 0);
    chk("rd_wide", cmd_wide, 0);
    chk("rd_addr", cmd_addr, 32'h0012345);
    cpu_addr = 25'h0000000;
    tick(); tick(); tick();
    chk("rd_ack_early", cpu_ack, 0);
    tick();
    chk("rd_ack", cpu_ack, 1);
    chk("rd_dout", cpu_dout, 8'h23);
    cpu_req = 1'b0;
    tick();
    chk("rd_ack_one", cpu_ack, 0);

    // CPU write raised at phase 7 goes out in the CPU slot.
    wait_ph(7);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h0000010; cpu_din = 8'h5A;
    tick();
    chk("wr_start", cmd_start, 1);
    chk("wr_we", cmd_we, 1);
    chk("wr_wide", cmd_wide, 0);
    chk("wr_din", cmd_din, 8'h5A);
    chk("wr_addr", cmd_addr, 32'h10);
    cpu_din = 8'h00;
    tick(); tick(); tick();
    chk("wr_ack_early", cpu_ack, 0);
    tick();
    chk("wr_ack", cpu_ack, 1);
    chk("wr_no_reissue", cmd_start, 0);
    chk("wr_dout_kept", cpu_dout, 8'h23);
    cpu_req = 1'b0; cpu_we = 1'b0;

    // Two download strobes in one wheel: the second overflows.
    wait_ph(5);
    misc_wr = 1'b1; misc_addr = 25'h1F00001; misc_din = 8'h77;
    tick();
    misc_wr = 1'b0;
    chk("m1_busy", misc_busy, 1);
    chk("m1_ovf", misc_ovf, 0);
    wait_ph(10);
    misc_wr = 1'b1; misc_addr = 25'h0000055; misc_din = 8'h88;
    tick();
    misc_wr = 1'b0;
    chk("m2_ovf", misc_ovf, 1);
    chk("m2_busy", misc_busy, 1);
    tick();
    chk("m_start", cmd_start, 1);
    chk("m_we", cmd_we, 1);
    chk("m_wide", cmd_wide, 0);
    chk("m_din", cmd_din, 8'h77);
    chk("m_addr", cmd_addr, 32'h1F00001);
    chk("m_busy_fall", misc_busy, 0);

    // Download and CPU both pending at the shared slot: download wins.
    wait_ph(9);
    misc_wr = 1'b1; misc_addr = 25'h0000200; misc_din = 8'h99;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h00100A4;
    tick();
    misc_wr = 1'b0;
    tick(); tick();
    chk("both_start", cmd_start, 1);
    chk("both_we", cmd_we, 1);
    chk("both_din", cmd_din, 8'h99);
    chk("both_addr", cmd_addr, 32'h200);
    wait_ph(8);
    chk("both_cpu_start", cmd_start, 1);
    chk("both_cpu_we", cmd_we, 0);
    chk("both_cpu_addr", cmd_addr, 32'h00100A4);
    wait_ph(12);
    chk("both_cpu_ack", cpu_ack, 1);
    chk("both_cpu_dout", cpu_dout, 8'hA4);
    chk("ovf_sticky", misc_ovf, 1);
    cpu_req = 1'b0;

    // Reset one cycle after a CPU read issue discards the read.
    wait_ph(7);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000033;
    tick();
    chk("rr_start", cmd_start, 1);
    chk("rr_addr", cmd_addr, 32'h33);
    tick();
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    chk("rr_ack0", cpu_ack, 0);
    chk("rr_dout0", cpu_dout, 8'hFF);
    chk("rr_ovf", misc_ovf, 0);
    chk("rr_start0", cmd_start, 0);
    tick();
    chk("rr_ack1", cpu_ack, 0);
    chk("rr_dout1", cpu_dout, 8'hFF);
    reset = 1'b0;
    lab = -1;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("rr_no_ack", cpu_ack, 0);
      chk("rr_dout", cpu_dout, 8'hFF);
      if (lab == 0) begin
        chk("rr_v1_start", cmd_start, 1);
        chk("rr_v1_wide", cmd_wide, 1);
        chk("rr_v1_addr", cmd_addr, 32'h0082468);
        chk("rr_vid1_clr", vid_data1, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
